// File: rtl/axi_lite_regfile_if.sv
// AXI-Lite bus bundle between one master and the register bank.
interface axi_lite_regfile_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI-Lite slave register bank: NUM_RW byte-writable control registers
// followed by NUM_RO read-only status inputs, with independent read/write FSMs.
module axi_lite_regfile #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    NUM_RW     = 8,
  parameter int                    NUM_RO     = 8,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  axi_lite_regfile_if.slave                 s_axi,
  output logic [NUM_RW*DATA_WIDTH-1:0]      o_ctrl,
  input  logic [NUM_RO*DATA_WIDTH-1:0]      i_status,
  output logic                              o_wr_pulse,
  output logic [$clog2(NUM_RW+NUM_RO)-1:0]  o_wr_idx
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_AW = ADDR_WIDTH - OFF_W;
  localparam int IDX_W  = $clog2(NUM_RW + NUM_RO);
  localparam logic [IDX_AW-1:0] RW_END = IDX_AW'(NUM_RW);
  localparam logic [IDX_AW-1:0] RO_END = IDX_AW'(NUM_RW + NUM_RO);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [NUM_RW-1:0][DATA_WIDTH-1:0] ctrl_q;
  logic [NUM_RO-1:0][DATA_WIDTH-1:0] status;

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [1:0]            bresp_q;

  logic                  w_open, aw_hs, w_hs, commit, cm_rw;
  logic [ADDR_WIDTH-1:0] cm_addr;
  logic [DATA_WIDTH-1:0] cm_data;
  logic [STRB_W-1:0]     cm_strb;
  logic [IDX_AW-1:0]     cm_idx;
  logic [1:0]            cm_resp;

  logic                  ar_open, ar_hs;
  logic [IDX_AW-1:0]     rd_idx;
  logic [DATA_WIDTH-1:0] rd_data, rdata_q;
  logic [1:0]            rd_resp, rresp_q;

  assign status = i_status;
  assign o_ctrl = ctrl_q;

  // Write path: AW and W are collected independently; commit once both are present
  assign w_open        = (w_state == W_IDLE) && !i_rst;
  assign s_axi.awready = w_open && !aw_held;
  assign s_axi.wready  = w_open && !w_held;
  assign s_axi.bvalid  = (w_state == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign aw_hs         = s_axi.awvalid && w_open && !aw_held;
  assign w_hs          = s_axi.wvalid && w_open && !w_held;
  assign commit        = w_open && (aw_held || aw_hs) && (w_held || w_hs);

  assign cm_addr = aw_held ? aw_addr_q : s_axi.awaddr;
  assign cm_data = w_held  ? w_data_q  : s_axi.wdata;
  assign cm_strb = w_held  ? w_strb_q  : s_axi.wstrb;
  assign cm_idx  = cm_addr[ADDR_WIDTH-1:OFF_W];
  assign cm_resp = (cm_idx < RW_END) ? OKAY : (cm_idx < RO_END) ? SLVERR : DECERR;
  assign cm_rw   = commit && (cm_idx < RW_END);

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (commit) w_state_nxt = W_RESP;
      W_RESP:  if (s_axi.bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_state    <= W_IDLE;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= OKAY;
      o_wr_pulse <= 1'b0;
      o_wr_idx   <= '0;
    end else begin
      w_state    <= w_state_nxt;
      o_wr_pulse <= cm_rw;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= cm_resp;
        if (cm_rw) o_wr_idx <= cm_idx[IDX_W-1:0];
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= s_axi.awaddr;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_axi.wdata;
          w_strb_q <= s_axi.wstrb;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RW; k++) begin : g_ctrl
    logic [DATA_WIDTH-1:0] r;
    always_ff @(posedge i_clk) begin
      if (i_rst) r <= RST_VAL;
      else if (cm_rw && cm_idx == IDX_AW'(k))
        for (int b = 0; b < STRB_W; b++)
          if (cm_strb[b]) r[b*8 +: 8] <= cm_data[b*8 +: 8];
    end
    assign ctrl_q[k] = r;
  end

  // Read path: data is captured at the AR edge, so a same-edge commit is not yet visible
  assign ar_open       = (r_state == R_IDLE) && !i_rst;
  assign s_axi.arready = ar_open;
  assign ar_hs         = s_axi.arvalid && ar_open;
  assign s_axi.rvalid  = (r_state == R_DATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign rd_idx        = s_axi.araddr[ADDR_WIDTH-1:OFF_W];

  always_comb begin
    rd_data = '0;
    rd_resp = DECERR;
    for (int k = 0; k < NUM_RW; k++)
      if (rd_idx == IDX_AW'(k)) begin
        rd_data = ctrl_q[k];
        rd_resp = OKAY;
      end
    for (int k = 0; k < NUM_RO; k++)
      if (rd_idx == IDX_AW'(NUM_RW + k)) begin
        rd_data = status[k];
        rd_resp = OKAY;
      end
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (s_axi.rready) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else begin
      r_state <= r_state_nxt;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, cm_addr[OFF_W-1:0], s_axi.araddr[OFF_W-1:0]};
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Scoreboard bench for axi_lite_regfile: directed scenarios plus a randomized
// phase, all checked against a register-array model of the bank.
module tb_axi_lite_regfile;
  localparam int AW = 16, DW = 64, NRW = 8, NRO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_lite_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [NRW*DW-1:0] ctrl;
  logic [NRO*DW-1:0] status;
  logic              wr_pulse;
  logic [3:0]        wr_idx;

  axi_lite_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RW(NRW), .NUM_RO(NRO), .RST_VAL('0)) dut (
    .i_clk(clk), .i_rst(rst), .s_axi(bus),
    .o_ctrl(ctrl), .i_status(status), .o_wr_pulse(wr_pulse), .o_wr_idx(wr_idx)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rsp_t;

  logic [DW-1:0] ctrl_m [NRW];
  logic [DW-1:0] stat_m [NRO];
  rsp_t          exp_r [$];
  logic [1:0]    exp_b [$];
  int            exp_p [$];
  int            total = 0, bad = 0;
  bit            rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: condition not met", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      bus.bready = 1'($urandom_range(0, 1));
      bus.rready = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'(a) / (DW / 8);
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] s);
    int i = idx_of(a);
    if (i < NRW) begin
      for (int b = 0; b < 8; b++)
        if (s[b]) ctrl_m[i][8*b +: 8] = d[8*b +: 8];
      exp_b.push_back(2'b00);
      exp_p.push_back(i);
    end else if (i < NRW + NRO) exp_b.push_back(2'b10);
    else exp_b.push_back(2'b11);
  endtask

  function automatic rsp_t model_read(input logic [AW-1:0] a);
    rsp_t r;
    int   i = idx_of(a);
    r.data = '0;
    r.resp = 2'b11;
    if (i < NRW) begin
      r.data = ctrl_m[i];
      r.resp = 2'b00;
    end else if (i < NRW + NRO) begin
      r.data = stat_m[i-NRW];
      r.resp = 2'b00;
    end
    return r;
  endfunction

  task automatic chk_ctrl();
    for (int k = 0; k < NRW; k++) chk($sformatf("ctrl[%0d]", k), ctrl[k*DW +: DW], ctrl_m[k]);
  endtask

  task automatic wait_b();
    int n = 0;
    while (exp_b.size() != 0 && n < 200) begin tick(); n++; end
    if (exp_b.size() != 0) fail_now("timeout_bresp");
  endtask

  task automatic wait_r();
    int n = 0;
    while (exp_r.size() != 0 && n < 200) begin tick(); n++; end
    if (exp_r.size() != 0) fail_now("timeout_rdata");
  endtask

  task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] s,
                             input int aw_dly, input int w_dly);
    bit aw_done = 1'b0, w_done = 1'b0, aw_hit, w_hit;
    int c = 0;
    model_write(a, d, s);
    bus.awaddr = a;
    bus.wdata  = d;
    bus.wstrb  = s;
    while (!(aw_done && w_done) && c < 60) begin
      bus.awvalid = !aw_done && (c >= aw_dly);
      bus.wvalid  = !w_done && (c >= w_dly);
      @(negedge clk);
      if (aw_done) chk("awready_low_while_held", 64'(bus.awready), 64'd0);
      if (w_done)  chk("wready_low_while_held", 64'(bus.wready), 64'd0);
      aw_hit = bus.awvalid && bus.awready;
      w_hit  = bus.wvalid && bus.wready;
      tick();
      aw_done |= aw_hit;
      w_done  |= w_hit;
      c++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (!(aw_done && w_done)) fail_now("timeout_aw_w");
    else chk("bvalid_after_commit", 64'(bus.bvalid), 64'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] s,
                          input int aw_dly, input int w_dly);
    issue_write(a, d, s, aw_dly, w_dly);
    wait_b();
    chk_ctrl();
    chk("wr_pulse_seen", 64'(exp_p.size()), 64'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    bit hit = 1'b0;
    int c = 0;
    exp_r.push_back(model_read(a));
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    while (!hit && c < 60) begin
      @(negedge clk);
      hit = bus.arready;
      tick();
      c++;
    end
    bus.arvalid = 1'b0;
    if (!hit) fail_now("timeout_ar");
    else chk("rvalid_after_ar", 64'(bus.rvalid), 64'd1);
    wait_r();
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rst = 1'b1;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    for (int k = 0; k < NRW; k++) ctrl_m[k] = '0;
    for (int k = 0; k < NRO; k++) stat_m[k] = {$urandom, $urandom};
    stat_m[2] = 64'hDEADBEEF;
    for (int k = 0; k < NRO; k++) status[k*DW +: DW] = stat_m[k];

    // monitor: pops the scoreboard whenever a response or strobe is presented
    fork
      begin
        rsp_t e;
        forever begin
          @(negedge clk);
          if (!rst) begin
            if (bus.bvalid && bus.bready) begin
              if (exp_b.size() == 0) fail_now("bvalid_unexpected");
              else chk("bresp", 64'(bus.bresp), 64'(exp_b.pop_front()));
            end
            if (bus.rvalid && bus.rready) begin
              if (exp_r.size() == 0) fail_now("rvalid_unexpected");
              else begin
                e = exp_r.pop_front();
                chk("rdata", bus.rdata, e.data);
                chk("rresp", 64'(bus.rresp), 64'(e.resp));
              end
            end
            if (wr_pulse) begin
              if (exp_p.size() == 0) fail_now("wr_pulse_unexpected");
              else chk("wr_idx", 64'(wr_idx), 64'(exp_p.pop_front()));
            end
          end
        end
      end
    join_none

    repeat (3) tick();
    @(negedge clk);
    chk("rst_awready", 64'(bus.awready), 64'd0);
    chk("rst_wready", 64'(bus.wready), 64'd0);
    chk("rst_arready", 64'(bus.arready), 64'd0);
    chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst_rdata", bus.rdata, 64'd0);
    chk("rst_wr_pulse", 64'(wr_pulse), 64'd0);
    chk("rst_wr_idx", 64'(wr_idx), 64'd0);
    chk_ctrl();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", 64'(bus.awready), 64'd1);
    chk("post_rst_wready", 64'(bus.wready), 64'd1);
    chk("post_rst_arready", 64'(bus.arready), 64'd1);
    tick();

    // full write, partial write with W leading AW, RO and undecoded writes
    do_write(16'h0010, 64'h1122334455667788, 8'hFF, 0, 0);
    do_write(16'h0008, 64'hAAAAAAAABBBBBBBB, 8'h0F, 3, 0);
    chk("ctrl1_partial", ctrl[1*DW +: DW], 64'h00000000BBBBBBBB);
    do_write(16'h0048, 64'h5555, 8'hFF, 0, 0);
    do_write(16'h0200, 64'h6666, 8'hFF, 1, 0);

    // status read held by rready low
    bus.rready = 1'b0;
    exp_r.push_back(model_read(16'h0050));
    bus.araddr  = 16'h0050;
    bus.arvalid = 1'b1;
    @(negedge clk);
    chk("arready_idle", 64'(bus.arready), 64'd1);
    tick();
    bus.arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rvalid_hold", 64'(bus.rvalid), 64'd1);
      chk("rdata_hold", bus.rdata, 64'hDEADBEEF);
      chk("arready_busy", 64'(bus.arready), 64'd0);
      tick();
    end
    bus.rready = 1'b1;
    wait_r();
    do_read(16'h0400);

    // bready stall; reads keep flowing meanwhile
    bus.bready = 1'b0;
    issue_write(16'h0018, 64'h0123456789ABCDEF, 8'hFF, 0, 0);
    do_read(16'h0010);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_bvalid", 64'(bus.bvalid), 64'd1);
      chk("stall_awready", 64'(bus.awready), 64'd0);
      chk("stall_wready", 64'(bus.wready), 64'd0);
      tick();
    end
    bus.bready = 1'b1;
    wait_b();
    chk_ctrl();

    // same-edge read and write of register 0: read sees the old value
    do_write(16'h0000, 64'd5, 8'hFF, 0, 0);
    exp_r.push_back(model_read(16'h0000));
    model_write(16'h0000, 64'd7, 8'hFF);
    bus.araddr = 16'h0000; bus.arvalid = 1'b1;
    bus.awaddr = 16'h0000; bus.awvalid = 1'b1;
    bus.wdata = 64'd7; bus.wstrb = 8'hFF; bus.wvalid = 1'b1;
    @(negedge clk);
    chk("same_edge_arready", 64'(bus.arready), 64'd1);
    chk("same_edge_awready", 64'(bus.awready), 64'd1);
    chk("same_edge_wready", 64'(bus.wready), 64'd1);
    tick();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    wait_b();
    wait_r();
    chk_ctrl();
    do_read(16'h0000);

    // randomized traffic with random backpressure
    rand_rdy = 1'b1;
    repeat (150) begin
      a = 16'($urandom_range(0, (NRW + NRO + 4) * 8 - 1));
      if ($urandom_range(0, 9) == 0) a = 16'($urandom);
      d = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1)
        do_write(a, d, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a);
    end
    rand_rdy = 1'b0;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    tick();

    // reset while the write response is pending
    bus.bready = 1'b0;
    issue_write(16'h0020, 64'hCAFEF00D12345678, 8'hFF, 0, 0);
    rst = 1'b1;
    tick();
    exp_b.delete();
    exp_p.delete();
    for (int k = 0; k < NRW; k++) ctrl_m[k] = '0;
    chk("abort_bvalid", 64'(bus.bvalid), 64'd0);
    chk("abort_awready", 64'(bus.awready), 64'd0);
    chk("abort_wr_pulse", 64'(wr_pulse), 64'd0);
    chk_ctrl();
    bus.bready = 1'b1;
    rst = 1'b0;
    tick();
    chk("recover_awready", 64'(bus.awready), 64'd1);
    do_read(16'h0010);
    do_write(16'h0038, 64'h0F0F0F0F0F0F0F0F, 8'hC3, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_lite_regfile.md
# axi_lite_regfile

AXI-Lite slave register bank that terminates one AXI-Lite master port and exposes a bank of control (read/write) and status (read-only) registers to the surrounding logic. It sits directly downstream of an AXI-Lite master connection: it accepts the read-address, read-data, write-address, write-data and write-response channels and produces configuration outputs and write-event pulses for the datapath.

## Interface
- ADDR_WIDTH, 16, byte address width.
- DATA_WIDTH, 64, data width; 32 or 64 only.
- NUM_RW, 8, number of read/write control registers (indices 0..NUM_RW-1).
- NUM_RO, 8, number of read-only status registers (indices NUM_RW..NUM_RW+NUM_RO-1).
- RST_VAL, 0, reset value of every control register.

- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_awaddr / i_awprot / i_awvalid / o_awready  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel.
- i_wdata / i_wstrb / i_wvalid / o_wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- o_bresp / o_bvalid / i_bready  out/out/in  2/1/1  write response channel.
- i_araddr / i_arprot / i_arvalid / o_arready  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel.
- o_rdata / o_rresp / o_rvalid / i_rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel.
- o_ctrl  out  NUM_RW*DATA_WIDTH  flattened control registers, index k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_status  in  NUM_RO*DATA_WIDTH  flattened status inputs, same packing.
- o_wr_pulse  out  1  one-cycle strobe on each committed control-register write.
- o_wr_idx  out  $clog2(NUM_RW+NUM_RO)  register index of the last write commit.

## Operation
- Register index = addr >> log2(DATA_WIDTH/8); low byte-offset bits ignored. *prot ignored.
- Write path, states W_IDLE, W_RESP. In W_IDLE, AW and W are accepted independently: o_awready = no AW held; o_wready = no W held. A handshake latches addr or data+strb into a holding register.
- Commit happens on the edge where both AW and W are available (held, or handshaking that edge; same-cycle AW+W allowed). On commit: go to W_RESP, o_bvalid=1, both holds cleared.
- Commit effect: index < NUM_RW → per byte lane, byte updated iff wstrb bit set, o_bresp=OKAY(00), o_wr_pulse=1, o_wr_idx=index. Index in RO range → no update, SLVERR(10), no pulse. Index ≥ NUM_RW+NUM_RO → no update, DECERR(11), no pulse.
- W_RESP: o_awready=o_wready=0; o_bvalid/o_bresp held until i_bready; on handshake → W_IDLE.
- Read path, states R_IDLE, R_DATA. R_IDLE: o_arready=1. On AR handshake: o_rdata captured (control reg, status input, or 0 for out-of-range), o_rresp OKAY or DECERR, → R_DATA with o_rvalid=1. R_DATA: o_arready=0, o_rdata/o_rresp stable until i_rready, then → R_IDLE.
- Read and write paths fully independent; may be active in the same cycle.
- Same-edge AR handshake and commit to the same register: read returns pre-write value.
- Status inputs sampled only at the AR handshake edge.

## Timing
- While i_rst=1 (sampled at edge): all ready/valid outputs 0, o_bresp=o_rresp=0, o_rdata=0, o_wr_pulse=0, o_wr_idx=0, o_ctrl=RST_VAL, holds cleared, FSMs in idle. First cycle after reset: o_awready=o_wready=o_arready=1.
- Reset mid-transaction aborts it; no response issued for it.
- Write latency: commit edge = edge of last of AW/W handshakes; o_bvalid and updated o_ctrl visible the following cycle; o_wr_pulse high exactly that one cycle.
- Read latency: o_rvalid high the cycle after AR handshake.
- Max throughput: one write per 2 cycles, one read per 2 cycles with bready/rready held high.
- o_ctrl changes only on commit or reset.

## Test plan
- Reset then write idx 2 (addr 0x10), wdata 0x1122334455667788, wstrb 0xFF, AW+W same cycle, bready=1 -> bvalid next cycle, bresp 00, wr_pulse 1 cycle with wr_idx 2, ctrl[2]=0x1122334455667788.
- W three cycles before AW to idx 1, wstrb 0x0F, data 0xAAAAAAAABBBBBBBB over 0 -> wready low after W, commit on AW edge, ctrl[1]=0x00000000BBBBBBBB.
- Write idx 9 (RO) and addr 0x200 -> bresp 10 then 11, o_ctrl unchanged, no wr_pulse.
- Read idx 10 with i_status[2]=0xDEADBEEF, rready held low 4 cycles -> rvalid and rdata 0xDEADBEEF stable, arready 0, then release; read addr 0x400 -> rdata 0, rresp 11.
- bready low 5 cycles after commit -> awready/wready 0, new AW/W not accepted, bvalid held; concurrent reads still complete.
- Same-edge read+write idx 0 (old 5, new 7) -> rdata 5, subsequent read 7; assert i_rst during W_RESP -> bvalid 0 next cycle, ctrl=RST_VAL.
